// File: rtl/fetch_unit_if.sv
// Fetch unit bus: program control, ROM fetch and retirement status.
//   start_i/start_addr_i : launch a program at an entry address
//   stall_i              : freeze PC/state for the cycle
//   inst_i               : ROM data for address_o (combinational ROM)
//   flag_i/offset_i      : branch condition and unsigned distance
//   address_o            : current PC
//   inst_o/inst_valid_o  : instruction issued this cycle
//   done_o/cycles_o      : halt retired / executed-instruction count
interface fetch_unit_if;
    logic        start_i;
    logic [7:0]  start_addr_i;
    logic        stall_i;
    logic [7:0]  inst_i;
    logic        flag_i;
    logic [7:0]  offset_i;
    logic [7:0]  address_o;
    logic [7:0]  inst_o;
    logic        inst_valid_o;
    logic        done_o;
    logic [15:0] cycles_o;

    // Driver side: control, ROM and execute stage
    modport master (
        output start_i, start_addr_i, stall_i, inst_i, flag_i, offset_i,
        input  address_o, inst_o, inst_valid_o, done_o, cycles_o
    );

    // Fetch unit side
    modport slave (
        input  start_i, start_addr_i, stall_i, inst_i, flag_i, offset_i,
        output address_o, inst_o, inst_valid_o, done_o, cycles_o
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC sequencing with halt, conditional
// forward/backward branches, stall and start/restart control.
// Ports:
//   clk_i      : clock, rising edge
//   reset_n_i  : synchronous active-low reset
//   bus        : fetch_unit_if.slave (see interface for signal list)
// address_o, done_o and cycles_o are registered; inst_valid_o and
// inst_o are combinational from state and stall_i/inst_i.
module fetch_unit #(
    parameter logic [7:0] START_DEFAULT = 8'd0
) (
    input  logic         clk_i,
    input  logic         reset_n_i,
    fetch_unit_if.slave  bus
);
    localparam int unsigned AW = 8;
    localparam int unsigned CW = 16;

    localparam logic [AW-1:0] HALT_OP = 8'b1000_1000;
    localparam logic [4:0]    FWD_OP  = 5'b11110;
    localparam logic [4:0]    BWD_OP  = 5'b10110;
    localparam logic [CW-1:0] CYC_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_pc, w_pc_nxt;
    logic          r_done, w_done_nxt;
    logic [CW-1:0] r_cycles, w_cycles_nxt;

    logic w_inst_valid;
    logic w_is_halt;
    logic w_is_fwd;
    logic w_is_bwd;

    // Issue qualifier: only a non-stalled RUN cycle executes an instruction
    assign w_inst_valid = (r_state == RUN) && !bus.stall_i;

    // Instruction class decode
    assign w_is_halt = (bus.inst_i == HALT_OP);
    assign w_is_fwd  = (bus.inst_i[7:3] == FWD_OP);
    assign w_is_bwd  = (bus.inst_i[7:3] == BWD_OP);

    // State register
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state  <= IDLE;
            r_pc     <= START_DEFAULT;
            r_done   <= 1'b0;
            r_cycles <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_done   <= w_done_nxt;
            r_cycles <= w_cycles_nxt;
        end
    end

    // Next-state, PC and counter logic
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_done_nxt   = r_done;
        w_cycles_nxt = r_cycles;

        unique case (r_state)
            IDLE, HALTED: begin
                if (bus.start_i) begin
                    w_state_nxt  = RUN;
                    w_pc_nxt     = bus.start_addr_i;
                    w_done_nxt   = 1'b0;
                    w_cycles_nxt = '0;
                end
            end
            RUN: begin
                // Stall holds everything, including a pending halt
                if (w_inst_valid) begin
                    if (r_cycles != CYC_MAX) begin
                        w_cycles_nxt = r_cycles + CW'(1);
                    end
                    if (w_is_halt) begin
                        w_state_nxt = HALTED;
                        w_done_nxt  = 1'b1;
                    end else if (w_is_fwd && bus.flag_i) begin
                        w_pc_nxt = r_pc + AW'(1) + bus.offset_i;
                    end else if (w_is_bwd && bus.flag_i) begin
                        w_pc_nxt = r_pc + AW'(1) - bus.offset_i;
                    end else begin
                        w_pc_nxt = r_pc + AW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.address_o    = r_pc;
    assign bus.done_o       = r_done;
    assign bus.cycles_o     = r_cycles;
    assign bus.inst_valid_o = w_inst_valid;
    assign bus.inst_o       = w_inst_valid ? bus.inst_i : 8'h00;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model of the program rules.
module tb_fetch_unit;
    localparam logic [7:0] SD = 8'd7;
    localparam int M_IDLE = 0, M_RUN = 1, M_HALTED = 2;

    int errors = 0;
    int checks = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] rom [256];

    fetch_unit_if bus ();
    assign bus.inst_i = rom[bus.address_o];

    fetch_unit #(.START_DEFAULT(SD)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    // Behavioural model state
    int m_state = M_IDLE;
    int m_pc    = int'(SD);
    int m_done  = 0;
    int m_cycles = 0;

    // Apply one clock edge worth of program rules to the model
    task automatic model_edge();
        int inst;
        int off;
        inst = int'(rom[m_pc]);
        off  = int'(bus.offset_i);
        if (!rst_n) begin
            m_state = M_IDLE; m_pc = int'(SD); m_done = 0; m_cycles = 0;
        end else if (m_state != M_RUN) begin
            if (bus.start_i) begin
                m_state = M_RUN; m_pc = int'(bus.start_addr_i);
                m_done = 0; m_cycles = 0;
            end
        end else if (!bus.stall_i) begin
            if (m_cycles < 65535) m_cycles = m_cycles + 1;
            if (inst == 136) begin
                m_state = M_HALTED; m_done = 1;
            end else if ((inst / 8) == 30 && bus.flag_i) begin
                m_pc = (m_pc + 1 + off) % 256;
            end else if ((inst / 8) == 22 && bus.flag_i) begin
                m_pc = (m_pc + 1 - off + 512) % 256;
            end else begin
                m_pc = (m_pc + 1) % 256;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.start_i = 1'b0;
        bus.stall_i = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic start_at(input logic [7:0] addr);
        bus.start_i = 1'b1;
        bus.start_addr_i = addr;
        step();
        bus.start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start_i = 1'b1;
        step();
        step();
        bus.start_i = 1'b0;
        #1;
        checks++;
        if (bus.address_o !== SD) begin
            errors++; $display("FAIL reset_addr: got %0d expected %0d", bus.address_o, SD);
        end
        checks++;
        if (bus.done_o !== 1'b0 || bus.cycles_o !== 16'd0) begin
            errors++; $display("FAIL reset_status: got done=%0b cycles=%0d expected 0/0", bus.done_o, bus.cycles_o);
        end
        checks++;
        if (bus.inst_valid_o !== 1'b0 || bus.inst_o !== 8'h00) begin
            errors++; $display("FAIL reset_issue: got valid=%0b inst=%h expected 0/00", bus.inst_valid_o, bus.inst_o);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (bus.address_o !== SD) begin
            errors++; $display("FAIL idle_hold: got %0d expected %0d", bus.address_o, SD);
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 5; i++) rom[i] = 8'(i);
        rom[5] = 8'h88;
        start_at(8'd0);
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if (bus.address_o !== 8'(k) || bus.inst_valid_o !== 1'b1 || bus.inst_o !== rom[k]) begin
                errors++;
                $display("FAIL seq_step%0d: got addr=%0d valid=%0b inst=%h expected %0d/1/%h",
                         k, bus.address_o, bus.inst_valid_o, bus.inst_o, k, rom[k]);
            end
            step();
        end
        checks++;
        if (bus.done_o !== 1'b1 || bus.cycles_o !== 16'd6 || bus.address_o !== 8'd5) begin
            errors++;
            $display("FAIL seq_halt: got done=%0b cycles=%0d addr=%0d expected 1/6/5",
                     bus.done_o, bus.cycles_o, bus.address_o);
        end
        step();
        checks++;
        if (bus.done_o !== 1'b1 || bus.address_o !== 8'd5 || bus.inst_valid_o !== 1'b0 || bus.cycles_o !== 16'd6) begin
            errors++;
            $display("FAIL seq_halted_hold: got done=%0b addr=%0d valid=%0b cycles=%0d expected 1/5/0/6",
                     bus.done_o, bus.address_o, bus.inst_valid_o, bus.cycles_o);
        end
    endtask

    task automatic test_branches();
        logic [7:0] st [5];
        logic [7:0] op [5];
        logic       fl [5];
        logic [7:0] of [5];
        logic [7:0] ex [5];
        st = '{8'd17, 8'd49, 8'd49, 8'd255, 8'd2};
        op = '{8'b11110111, 8'b10110110, 8'b10110110, 8'h00, 8'b10110000};
        fl = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        of = '{8'd8, 8'd38, 8'd38, 8'd99, 8'd10};
        ex = '{8'd26, 8'd12, 8'd50, 8'd0, 8'd249};
        for (int i = 0; i < 5; i++) begin
            do_reset();
            rom[st[i]] = op[i];
            start_at(st[i]);
            bus.flag_i = fl[i];
            bus.offset_i = of[i];
            step();
            checks++;
            if (bus.address_o !== ex[i] || bus.cycles_o !== 16'd1) begin
                errors++;
                $display("FAIL branch%0d: got addr=%0d cycles=%0d expected %0d/1",
                         i, bus.address_o, bus.cycles_o, ex[i]);
            end
        end
        bus.flag_i = 1'b0;
    endtask

    task automatic test_stall_restart();
        do_reset();
        rom[40] = 8'h01; rom[41] = 8'h02; rom[42] = 8'h88;
        start_at(8'd40);
        bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.inst_valid_o !== 1'b0 || bus.inst_o !== 8'h00) begin
                errors++; $display("FAIL stall_issue%0d: got valid=%0b inst=%h expected 0/00", i, bus.inst_valid_o, bus.inst_o);
            end
            step();
            checks++;
            if (bus.address_o !== 8'd40 || bus.cycles_o !== 16'd0) begin
                errors++; $display("FAIL stall_hold%0d: got addr=%0d cycles=%0d expected 40/0", i, bus.address_o, bus.cycles_o);
            end
        end
        bus.stall_i = 1'b0;
        step();
        bus.start_i = 1'b1;
        bus.start_addr_i = 8'd200;
        step();
        bus.start_i = 1'b0;
        checks++;
        if (bus.address_o !== 8'd42 || bus.cycles_o !== 16'd2) begin
            errors++; $display("FAIL start_in_run: got addr=%0d cycles=%0d expected 42/2", bus.address_o, bus.cycles_o);
        end
        bus.stall_i = 1'b1;
        step();
        checks++;
        if (bus.done_o !== 1'b0 || bus.cycles_o !== 16'd2) begin
            errors++; $display("FAIL stalled_halt: got done=%0b cycles=%0d expected 0/2", bus.done_o, bus.cycles_o);
        end
        bus.stall_i = 1'b0;
        step();
        checks++;
        if (bus.done_o !== 1'b1 || bus.cycles_o !== 16'd3 || bus.address_o !== 8'd42) begin
            errors++; $display("FAIL halt_retire: got done=%0b cycles=%0d addr=%0d expected 1/3/42",
                               bus.done_o, bus.cycles_o, bus.address_o);
        end
        start_at(8'd100);
        checks++;
        if (bus.address_o !== 8'd100 || bus.done_o !== 1'b0 || bus.cycles_o !== 16'd0) begin
            errors++; $display("FAIL restart: got addr=%0d done=%0b cycles=%0d expected 100/0/0",
                               bus.address_o, bus.done_o, bus.cycles_o);
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        rom[120] = 8'h01;
        start_at(8'd120);
        rst_n = 1'b0;
        bus.start_i = 1'b1;
        bus.start_addr_i = 8'd33;
        step();
        rst_n = 1'b1;
        bus.start_i = 1'b0;
        #1;
        checks++;
        if (bus.address_o !== SD || bus.inst_valid_o !== 1'b0 || bus.cycles_o !== 16'd0 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: got addr=%0d valid=%0b cycles=%0d done=%0b expected %0d/0/0/0",
                     bus.address_o, bus.inst_valid_o, bus.cycles_o, bus.done_o, SD);
        end
        step();
        checks++;
        if (bus.address_o !== SD) begin
            errors++; $display("FAIL reset_then_idle: got addr=%0d expected %0d", bus.address_o, SD);
        end
    endtask

    task automatic test_random();
        int cls;
        int exp_valid;
        for (int a = 0; a < 256; a++) begin
            cls = int'($urandom_range(0, 9));
            if (cls == 0)      rom[a] = 8'h88;
            else if (cls <= 2) rom[a] = {5'b11110, 3'($urandom)};
            else if (cls <= 4) rom[a] = {5'b10110, 3'($urandom)};
            else               rom[a] = 8'($urandom);
        end
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_n            = ($urandom_range(0, 199) != 0);
            bus.start_i      = ($urandom_range(0, 15) == 0);
            bus.start_addr_i = 8'($urandom);
            bus.stall_i      = ($urandom_range(0, 3) == 0);
            bus.flag_i       = 1'($urandom);
            bus.offset_i     = 8'($urandom);
            #1;
            exp_valid = (m_state == M_RUN && !bus.stall_i) ? 1 : 0;
            checks++;
            if (bus.address_o !== 8'(m_pc) || bus.done_o !== 1'(m_done) || bus.cycles_o !== 16'(m_cycles)) begin
                errors++;
                $display("FAIL rand_state c=%0d: got addr=%0d done=%0b cycles=%0d expected %0d/%0d/%0d",
                         c, bus.address_o, bus.done_o, bus.cycles_o, m_pc, m_done, m_cycles);
            end
            checks++;
            if (bus.inst_valid_o !== 1'(exp_valid) ||
                bus.inst_o !== (exp_valid != 0 ? rom[m_pc] : 8'h00)) begin
                errors++;
                $display("FAIL rand_issue c=%0d: got valid=%0b inst=%h expected %0d/%h",
                         c, bus.inst_valid_o, bus.inst_o, exp_valid, (exp_valid != 0 ? rom[m_pc] : 8'h00));
            end
            step();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        bus.start_i      = 1'b0;
        bus.start_addr_i = 8'd0;
        bus.stall_i      = 1'b0;
        bus.flag_i       = 1'b0;
        bus.offset_i     = 8'd0;
        for (int a = 0; a < 256; a++) rom[a] = 8'h00;
        test_reset();
        test_sequential();
        test_branches();
        test_stall_restart();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
